// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch unit.
// The memory image starts out as all NOPs so an unloaded core executes harmlessly.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int          DEF_ADDR_W      = 6;
    localparam int          DEF_DATA_W      = 32;
    localparam int          DEF_WAIT_STATES = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one asynchronous read port.
// The fetch unit registers the read value on the same edge as a write, so reads see the old word.
module imem_array
    import imem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Power-up image only; reset never touches the contents.
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: DATA_W'(NOP_INSTR)};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with a registered request/response fetch interface,
// configurable wait states, a boot-time program port and a retired-fetch counter.
module imem_fetch
    import imem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = DEF_WAIT_STATES
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W+1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [31:0]       fetch_cnt
);

    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    imem_state_t       state;
    imem_state_t       state_next;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              accept;
    logic              rsp_fire;
    logic              capture;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_err;
    logic [DATA_W-1:0] rd_data;

    assign rsp_valid = (state == RESP);
    assign req_ready = !prog_en && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Zero-wait fetches read straight from the request; otherwise from the latched address.
    assign capture = ((state == WAIT) && (wait_cnt == 3'd0)) || (accept && (WAIT_STATES == 0));
    assign rd_addr = (state == WAIT) ? addr_q : req_addr[ADDR_W+1:2];
    assign rd_err  = (state == WAIT) ? err_q  : (req_addr[1:0] != 2'b00);

    imem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (prog_en && prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        state_next = (WAIT_STATES == 0) ? RESP : WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 3'd0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            fetch_cnt <= 32'd0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr[ADDR_W+1:2];
                err_q    <= (req_addr[1:0] != 2'b00);
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            // Misaligned fetches return a zero word flagged with rsp_err.
            if (capture) begin
                rsp_err  <= rd_err;
                rsp_data <= rd_err ? '0 : rd_data;
            end
            if (rsp_fire) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory with a registered fetch interface for the RISC-V core. It replaces the combinational word-indexed instruction ROM with three additions: a byte-addressed fetch request/response handshake with configurable wait states, a program-load write port for boot-time loading, and a retired-fetch counter. It sits between the fetch stage (PC generation) and the decode stage.

## Interface
- `ADDR_W`, 6: word-index width; depth = 2^ADDR_W words.
- `DATA_W`, 32: instruction width.
- `WAIT_STATES`, 1: extra cycles between request acceptance and response, range 0..7.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: fetch request.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_addr` in ADDR_W+2: byte address; word index = `req_addr[ADDR_W+1:2]`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out DATA_W: fetched instruction.
- `rsp_err` out 1: misaligned request, i.e. `req_addr[1:0]` != 0.
- `prog_en` in 1: program mode; blocks new fetches.
- `prog_we` in 1: write strobe; ignored unless `prog_en` is high.
- `prog_addr` in ADDR_W: word index to write.
- `prog_data` in DATA_W: word to write.
- `fetch_cnt` out 32: number of completed response handshakes; wraps modulo 2^32.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE → WAIT** on an accepted request, when WAIT_STATES > 0. The address is latched and `wait_cnt` is loaded with WAIT_STATES−1.
- **IDLE → RESP** on an accepted request, when WAIT_STATES = 0.
- **WAIT:** `wait_cnt` decrements each cycle. At `wait_cnt` = 0, go to RESP.
- **Read capture:** the memory read occurs on the transition into RESP. `rsp_data`/`rsp_err` are registered and held stable throughout RESP.
- **RESP, leaving:** on `rsp_valid && rsp_ready`:
  - if a new request is accepted in the same cycle, go to WAIT or RESP, as from IDLE;
  - otherwise go to IDLE.
- **Ready rule:** `req_ready` = !`prog_en` && (state == IDLE || (state == RESP && `rsp_ready`)). At most one transaction is outstanding.
- **Misaligned request:**
  - latency is unchanged;
  - `rsp_err` = 1 and `rsp_data` = 0;
  - it still counts in `fetch_cnt`.
- **Program writes:**
  - `prog_en && prog_we` writes `prog_data` to `mem[prog_addr]` at the clock edge;
  - writes are allowed in any FSM state;
  - if a write hits the word being captured on the same edge, the response returns the old word (read-before-write).
- **`prog_en` raised mid-transaction:** the in-flight fetch completes normally; only new acceptance is blocked.
- **`fetch_cnt`:** increments by 1 on every RESP handshake, whether good or error.
- **Memory contents:**
  - initial contents are 32'h00000013 (NOP) in every word;
  - memory is not cleared by `rst`.

## Timing
- **Reset values:**
  - state = IDLE;
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0;
  - `fetch_cnt` = 0;
  - `wait_cnt` = 0;
  - `req_ready` = !`prog_en` from the first cycle after reset.
- **Latency:** `rsp_valid` rises WAIT_STATES+1 cycles after the accepting edge.
- **Throughput:** one fetch per WAIT_STATES+1 cycles with `rsp_ready` held high. With WAIT_STATES = 0 this is back-to-back, one per cycle.
- **Backpressure:** `rsp_ready` low holds RESP and all response outputs stable indefinitely.
- **Reset mid-operation:** reset in any state aborts the transaction. No response is issued for it and `fetch_cnt` is not incremented.
- **`prog_en` vs. request:** if `prog_en` and `req_valid` rise in the same cycle, the request is not accepted.

## Structure
- **Package `imem_pkg`:**
  - `NOP_INSTR` = 32'h00000013;
  - state enum `imem_state_t` {IDLE, WAIT, RESP};
  - default parameter constants.
- **Sub-module `imem_array`:**
  - 2^ADDR_W × DATA_W storage;
  - one synchronous write port;
  - one read port with read-before-write semantics.
- **Top `imem_fetch`:** FSM, wait counter, response registers, fetch counter.

## Test plan
- **Program + fetch (WAIT_STATES=1):** load mem[2]=32'h00C02183 via the program port; drop `prog_en`; request `req_addr`=8 → `rsp_valid` 2 cycles later, `rsp_data`=32'h00C02183, `rsp_err`=0, `fetch_cnt`=1.
- **Misaligned:** request `req_addr`=6 → `rsp_err`=1, `rsp_data`=0, same latency, `fetch_cnt` increments.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP → outputs stable and `req_ready`=0; then `rsp_ready`=1 with a new `req_valid` → new request accepted on the handshake edge.
- **Back-to-back (WAIT_STATES=0):** addresses 0, 4, 8, 12 on consecutive cycles with `rsp_ready`=1 → four consecutive responses returning NOP contents, `fetch_cnt`=4.
- **Write collision:** a `prog_we` to word 3 on the RESP-capture edge of a fetch of `req_addr`=12 → response returns the old word; a refetch returns the new word.
- **Reset mid-WAIT (WAIT_STATES=7):** assert `rst` 3 cycles after acceptance → `rsp_valid` never rises, `fetch_cnt`=0, state IDLE, and memory contents are preserved.
